traffic_phase_sequencer: RTL and testbench

Autonomous traffic-light phase sequencer that generates the 4-bit cycle code and flash-enable bit consumed by the intersection decoder. This puts local timing on the FPGA instead of the ESP32. It walks approaches 1→4 through green and amber phases on a 1 s time base derived from the board clock. It falls back to flashing amber on reset, on request, or when stopped. Its outputs drive the decoder's `ciclo_esp32[3:0]` and `dest_esp32` inputs directly; the decoder gates `dest_esp32` with the 1 Hz blink pulse.

---
 rtl/traffic_phase_sequencer.sv | 78 +++++++
 tb/tb_traffic_phase_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: 1 s-tick FLASH/GREEN/AMBER phase walker over approaches 1..4 (in clk, rst, run, flash_req; out ciclo, dest, phase_start, sec_left); define GREEN_BLINK_EN for blink during the last GREEN_BLINK_S seconds of green
module traffic_phase_sequencer #(
  parameter int CLK_HZ        = 27_000_000,
  parameter int GREEN_S       = 20,
  parameter int AMBER_S       = 3,
  parameter int GREEN_BLINK_S = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       flash_req,
  output logic [3:0] ciclo,
  output logic       dest,
  output logic       phase_start,
  output logic [7:0] sec_left
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  typedef enum logic [1:0] {FLASH, GREEN, AMBER} state_e;
  state_e st_q, st_d;
  logic [1:0] ap_q, ap_d;
  logic [PW-1:0] cnt_q;
  logic [7:0] sec_d;
  logic [3:0] ciclo_d;
  logic tick, stop, dest_d;
  always_comb begin
    tick = cnt_q == PW'(CLK_HZ - 1);
    stop = flash_req || !run;
    st_d = st_q;
    ap_d = ap_q;
    sec_d = sec_left;
    if (tick) begin
      if (st_q == FLASH) begin
        if (!stop) begin
          st_d = GREEN;
          ap_d = 2'd0;
          sec_d = 8'(GREEN_S);
        end
      end else if (sec_left == 8'd1 || (st_q == GREEN && stop)) begin
        if (st_q == GREEN) begin
          st_d = AMBER;
          sec_d = 8'(AMBER_S);
        end else if (stop) begin
          st_d = FLASH;
          sec_d = 8'd0;
        end else begin
          st_d = GREEN;
          ap_d = ap_q + 2'd1;
          sec_d = 8'(GREEN_S);
        end
      end else sec_d = sec_left - 8'd1;
    end
    ciclo_d = st_d == FLASH ? 4'd0 : {1'b0, ap_d, 1'b0} + (st_d == GREEN ? 4'd1 : 4'd2);
`ifdef GREEN_BLINK_EN
    dest_d = st_d == FLASH || (st_d == GREEN && sec_d <= 8'(GREEN_BLINK_S));
`else
    dest_d = st_d == FLASH;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      st_q <= FLASH;
      ap_q <= 2'd0;
      sec_left <= 8'd0;
      ciclo <= 4'd0;
      dest <= 1'b1;
      phase_start <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      st_q <= st_d;
      ap_q <= ap_d;
      sec_left <= sec_d;
      ciclo <= ciclo_d;
      dest <= dest_d;
      phase_start <= ciclo_d != ciclo;
    end
  end
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: scenario tasks plus random run/flash_req/rst stimulus against a phase-code reference model
module tb_traffic_phase_sequencer;
  localparam int CLK_HZ = 4, GREEN_S = 5, AMBER_S = 2, GREEN_BLINK_S = 2;
  logic clk = 0, rst = 1, run = 0, flash_req = 0;
  logic [3:0] ciclo;
  logic dest, phase_start;
  logic [7:0] sec_left;
  int errs = 0, chks = 0;
  int pc = 0, m_code = 0, m_sec = 0;
  bit m_ps = 0, m_dest = 1;
  logic [13:0] exp_v = '0;
  logic [13:0] act_v;
  assign act_v = {ciclo, dest, phase_start, sec_left};
  traffic_phase_sequencer #(
    .CLK_HZ(CLK_HZ), .GREEN_S(GREEN_S), .AMBER_S(AMBER_S), .GREEN_BLINK_S(GREEN_BLINK_S)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .flash_req(flash_req),
    .ciclo(ciclo), .dest(dest), .phase_start(phase_start), .sec_left(sec_left)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    int prev;
    bit tk, stp;
    if (rst) begin
      pc = 0;
      m_code = 0;
      m_sec = 0;
      m_ps = 0;
    end else begin
      prev = m_code;
      tk = pc == CLK_HZ - 1;
      pc = tk ? 0 : pc + 1;
      if (tk) begin
        stp = flash_req || !run;
        if (m_code == 0) begin
          if (!stp) begin m_code = 1; m_sec = GREEN_S; end
        end else if (m_code % 2 == 1) begin
          if (m_sec == 1 || stp) begin m_code = m_code + 1; m_sec = AMBER_S; end
          else m_sec = m_sec - 1;
        end else if (m_sec == 1) begin
          if (stp) begin m_code = 0; m_sec = 0; end
          else begin m_code = m_code == 8 ? 1 : m_code + 1; m_sec = GREEN_S; end
        end else m_sec = m_sec - 1;
      end
      m_ps = m_code != prev;
    end
`ifdef GREEN_BLINK_EN
    m_dest = m_code == 0 || (m_code % 2 == 1 && m_sec <= GREEN_BLINK_S);
`else
    m_dest = m_code == 0;
`endif
    exp_v = {4'(m_code), m_dest, m_ps, 8'(m_sec)};
  end
  task automatic do_reset(input logic r);
    rst = 1;
    run = r;
    flash_req = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    run = 0;
    flash_req = 0;
    repeat (3) @(negedge clk);
    chks++;
    if (act_v !== 14'b0000_1_0_00000000) begin errs++; $display("FAIL reset_vals: got %h want %h", act_v, 14'b0000_1_0_00000000); end
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chks++;
      if (act_v !== 14'b0000_1_0_00000000) begin errs++; $display("FAIL reset_hold cyc%0d: got %h want %h", i, act_v, 14'b0000_1_0_00000000); end
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL reset_model cyc%0d: got %h want %h", i, act_v, exp_v); end
    end
  endtask
  task automatic test_full_cycle;
    int codes[$];
    int stamps[$];
    logic [3:0] prev;
    do_reset(1);
    prev = 4'd0;
    for (int i = 0; i < 125; i++) begin
      @(negedge clk);
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL full_model cyc%0d: got %h want %h", i, act_v, exp_v); end
      chks++;
      if (phase_start !== (ciclo != prev)) begin errs++; $display("FAIL full_ps cyc%0d: got %b want %b", i, phase_start, ciclo != prev); end
      if (phase_start) begin codes.push_back(int'(ciclo)); stamps.push_back(i); end
      prev = ciclo;
    end
    chks++;
    if (codes.size() != 9) begin errs++; $display("FAIL full_count: got %0d want 9", codes.size()); end
    else for (int k = 0; k < 9; k++) begin
      chks++;
      if (codes[k] != (k % 8) + 1) begin errs++; $display("FAIL full_seq[%0d]: got %0d want %0d", k, codes[k], (k % 8) + 1); end
      if (k > 0) begin
        chks++;
        if (stamps[k] - stamps[k-1] != (codes[k-1] % 2 == 1 ? GREEN_S : AMBER_S) * CLK_HZ) begin
          errs++;
          $display("FAIL full_len[%0d]: got %0d want %0d", k, stamps[k] - stamps[k-1], (codes[k-1] % 2 == 1 ? GREEN_S : AMBER_S) * CLK_HZ);
        end
      end
    end
  endtask
  task automatic test_green_blink;
    int n;
    bit want;
    do_reset(1);
    n = 0;
    while (ciclo != 4'd3 && n < 200) begin @(negedge clk); n++; end
    chks++;
    if (ciclo != 4'd3) begin errs++; $display("FAIL blink_wait: got ciclo %0d want 3", ciclo); end
    n = 0;
    while (ciclo == 4'd3 && n < 40) begin
`ifdef GREEN_BLINK_EN
      want = sec_left <= 8'd2;
`else
      want = 1'b0;
`endif
      chks++;
      if (dest !== want) begin errs++; $display("FAIL blink_dest sec%0d: got %b want %b", sec_left, dest, want); end
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL blink_model: got %h want %h", act_v, exp_v); end
      @(negedge clk);
      n++;
    end
    chks++;
    if (n != GREEN_S * CLK_HZ) begin errs++; $display("FAIL blink_len: got %0d want %0d", n, GREEN_S * CLK_HZ); end
  endtask
  task automatic test_stop_green;
    int n;
    do_reset(1);
    n = 0;
    while (!(ciclo == 4'd5 && sec_left == 8'd4) && n < 200) begin
      @(negedge clk);
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL sg_model: got %h want %h", act_v, exp_v); end
      n++;
    end
    flash_req = 1;
    n = 0;
    while (ciclo == 4'd5 && n < 8) begin @(negedge clk); n++; end
    chks++;
    if (ciclo !== 4'd6 || sec_left !== 8'd2 || n > CLK_HZ) begin errs++; $display("FAIL sg_amber: got ciclo %0d sec %0d after %0d want 6 2 within %0d", ciclo, sec_left, n, CLK_HZ); end
    n = 0;
    while (ciclo == 4'd6 && n < 20) begin
      @(negedge clk);
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL sg_model2: got %h want %h", act_v, exp_v); end
      n++;
    end
    chks++;
    if (ciclo !== 4'd0 || n != AMBER_S * CLK_HZ) begin errs++; $display("FAIL sg_flash: got ciclo %0d after %0d want 0 after %0d", ciclo, n, AMBER_S * CLK_HZ); end
    flash_req = 0;
  endtask
  task automatic test_stop_amber;
    int n;
    do_reset(1);
    n = 0;
    while (ciclo != 4'd8 && n < 200) begin @(negedge clk); n++; end
    run = 0;
    n = 0;
    while (ciclo == 4'd8 && n < 20) begin
      @(negedge clk);
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL sa_model: got %h want %h", act_v, exp_v); end
      n++;
    end
    chks++;
    if (ciclo !== 4'd0 || n != AMBER_S * CLK_HZ) begin errs++; $display("FAIL sa_len: got ciclo %0d after %0d want 0 after %0d", ciclo, n, AMBER_S * CLK_HZ); end
    repeat (6) @(negedge clk);
    chks++;
    if (ciclo !== 4'd0 || dest !== 1'b1) begin errs++; $display("FAIL sa_hold: got ciclo %0d dest %b want 0 1", ciclo, dest); end
    run = 1;
    n = 0;
    while (ciclo == 4'd0 && n < 10) begin @(negedge clk); n++; end
    chks++;
    if (ciclo !== 4'd1 || n > CLK_HZ) begin errs++; $display("FAIL sa_restart: got ciclo %0d after %0d want 1 within %0d", ciclo, n, CLK_HZ); end
  endtask
  task automatic test_reset_mid_green;
    int n;
    do_reset(1);
    n = 0;
    while (ciclo != 4'd3 && n < 200) begin @(negedge clk); n++; end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chks++;
    if (ciclo !== 4'd0 || dest !== 1'b1 || sec_left !== 8'd0) begin errs++; $display("FAIL rm_flash: got ciclo %0d dest %b sec %0d want 0 1 0", ciclo, dest, sec_left); end
    n = 0;
    while (ciclo == 4'd0 && n < 10) begin @(negedge clk); n++; end
    chks++;
    if (ciclo !== 4'd1 || n != CLK_HZ) begin errs++; $display("FAIL rm_restart: got ciclo %0d after %0d want 1 after %0d", ciclo, n, CLK_HZ); end
  endtask
  task automatic test_random;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chks++;
      if (act_v !== exp_v) begin errs++; $display("FAIL rand_model cyc%0d: got %h want %h", i, act_v, exp_v); end
      if ($urandom_range(39) == 0) run = ~run;
      if ($urandom_range(59) == 0) flash_req = ~flash_req;
      rst = $urandom_range(499) == 0;
    end
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_full_cycle();
    test_green_blink();
    test_stop_green();
    test_stop_amber();
    test_reset_mid_green();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
